count_run_seq: RTL
==================

# count_run_seq

Parametrised serial run-length checker: consumes one bit per `read` strobe, frames every WIDTH bits as a word, and reports whether the word's target-polarity bits form a single contiguous run and how long that run is. Successor of the fixed 8-bit zero counter in the Lab 2 sequential datapath. Adds runtime polarity select, back-to-back word streaming, a held result register with a ready/ack handshake, and sticky overrun detection.

## Interface
- WIDTH, 8, bits per word; legal range 2..255.
- CNT_W, 4, width of the `count` output; must satisfy 2^CNT_W > WIDTH.
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- data  input  1  serial bit, valid when `read`=1.
- read  input  1  bit strobe; one word bit consumed per cycle with `read`=1.
- mode  input  1  target polarity: 0 counts zeros, 1 counts ones. Sampled only on the first bit of each word.
- ack  input  1  consumer acknowledge of the held result; ignored while `data_ready`=0.
- count  output  CNT_W  run length of the last completed word; 0 if that word was illegal.
- is_legal  output  1  last completed word matched non-target* target* non-target*.
- data_ready  output  1  result held and not yet acknowledged.
- overrun  output  1  sticky: a new result overwrote an unacknowledged one.

## Operation
- Word accumulator: bit index `idx` (0..WIDTH-1), latched polarity `pol`, run counter `run` (CNT_W bits), and scan FSM. All of these advance only on cycles with `read`=1.
- On `idx`=0, `pol` is loaded from `mode`. The bit is then classified against `mode` directly, not against the old `pol`.
- A bit is *target* when `data`==`pol`.
- FSM states: LEAD, RUN, TRAIL, BAD. The FSM is re-entered at LEAD for every word.
  - LEAD: a target bit increments `run` and moves to RUN. A non-target bit stays in LEAD.
  - RUN: a target bit increments `run`. A non-target bit moves to TRAIL.
  - TRAIL: a target bit moves to BAD. A non-target bit stays in TRAIL.
  - BAD: absorbing until end of word.
- On `idx`=WIDTH-1 with `read`=1, the word completes:
  - The result register loads `is_legal` = (final state != BAD) and `count` = legal ? final `run` : 0.
  - `data_ready` is set.
  - The accumulator resets to `idx`=0, LEAD, `run`=0. The next word may begin on the very next cycle.
- A word with no target bits is legal with `count`=0. A word of all target bits is legal with `count`=WIDTH.
- `read`=0 freezes the accumulator. There is no timeout.

## Timing
- Reset values: `count`=0, `is_legal`=1, `data_ready`=0, `overrun`=0. The accumulator is cleared to `idx`=0, LEAD, `run`=0, `pol`=0.
- `reset` has priority over `read` and `ack`. Asserting it mid-word discards the partial word and any held result.
- Latency: the result is visible on outputs in the cycle after the edge that samples the final bit. The minimum word period is WIDTH cycles.
- Handshake: `data_ready` stays 1, and `count`/`is_legal` hold stable, until an edge that samples `ack`=1. At that edge `data_ready` clears.
- Simultaneous `ack` and word completion on the same edge: the new result loads and `data_ready` remains 1. The old result counts as consumed, so there is no overrun.
- Word completion while `data_ready`=1 and `ack`=0: the new result overwrites the held one, `data_ready` remains 1, and `overrun` sets.
- `overrun` clears only on reset.
- `ack` while `data_ready`=0 has no effect.
- `mode` changes mid-word have no effect on the current word.

## Test plan
- Reset, WIDTH=8, mode=0, stream 1,1,0,0,0,1,1,1 with `read` held 1, `ack`=0. Required: 8 cycles after the first bit, `data_ready`=1, `count`=3, `is_legal`=1; values hold until `ack` is pulsed, then `data_ready`=0 the next cycle.
- mode=0, stream 1,0,1,0,1,1,1,1. Required: `is_legal`=0 and `count`=0 after completion.
- mode=1, stream 0,0,0,0,0,0,0,0 followed by 1×8. Required: first result `count`=0, `is_legal`=1; `ack` on the cycle of the second completion gives `count`=8, `is_legal`=1, `data_ready`=1, `overrun`=0.
- Two consecutive legal words with no `ack`. Required: `overrun`=1 after the second completion, outputs show the second word, and `overrun` is still 1 after a later `ack`, until reset.
- `read` toggled 1/0 every cycle over one word, with `mode` flipped mid-word. Required: the result equals the gap-free result computed using the polarity sampled on bit 0.
- Assert `reset` after 5 bits of a word. Required: all outputs return to reset values; the next 8 bits (1,0,0,1,1,1,1,1, mode=0) give `count`=2, `is_legal`=1.

Source files
------------

// File: rtl/count_run_seq.sv
// Serial run-length checker: frames WIDTH bits per word and reports whether the
// target-polarity bits form one contiguous run, holding the result under a ready/ack handshake.
module count_run_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             read,
    input  logic             mode,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             is_legal,
    output logic             data_ready,
    output logic             overrun
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {LEAD, RUN, TRAIL, BAD} state_t;

    state_t             state_q, state_d, scan_nxt;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pol_q, pol_d;
    logic [CNT_W-1:0]   run_q, run_d, run_nxt;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               legal_q, legal_d;
    logic               ready_q, ready_d;
    logic               ovr_q, ovr_d;

    logic               first_bit, last_bit, eff_pol, tgt;

    assign first_bit = (idx_q == '0);
    assign last_bit  = read && (idx_q == IDX_W'(WIDTH - 1));
    // The first bit is classified against mode directly, not the stale polarity.
    assign eff_pol   = first_bit ? mode : pol_q;
    assign tgt       = (data == eff_pol);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEAD;
            idx_q   <= '0;
            pol_q   <= 1'b0;
            run_q   <= '0;
            count_q <= '0;
            legal_q <= 1'b1;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pol_q   <= pol_d;
            run_q   <= run_d;
            count_q <= count_d;
            legal_q <= legal_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        scan_nxt = state_q;
        run_nxt  = run_q;
        case (state_q)
            LEAD: if (tgt) begin
                scan_nxt = RUN;
                run_nxt  = run_q + 1'b1;
            end
            RUN: begin
                if (tgt) run_nxt  = run_q + 1'b1;
                else     scan_nxt = TRAIL;
            end
            TRAIL: if (tgt) scan_nxt = BAD;
            default: scan_nxt = BAD;
        endcase
        state_d = state_q;
        if (read) state_d = last_bit ? LEAD : scan_nxt;
    end

    always_comb begin
        idx_d   = idx_q;
        pol_d   = pol_q;
        run_d   = run_q;
        count_d = count_q;
        legal_d = legal_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (read) begin
            if (first_bit) pol_d = mode;
            if (last_bit) begin
                idx_d = '0;
                run_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                run_d = run_nxt;
            end
        end
        if (ack) ready_d = 1'b0;
        if (last_bit) begin
            legal_d = (scan_nxt != BAD);
            count_d = (scan_nxt != BAD) ? run_nxt : '0;
            ready_d = 1'b1;
            // A same-edge ack consumes the old result, so only an unacked one overruns.
            if (ready_q && !ack) ovr_d = 1'b1;
        end
    end

    assign count      = count_q;
    assign is_legal   = legal_q;
    assign data_ready = ready_q;
    assign overrun    = ovr_q;
endmodule
